alu_issue_stage: RTL and testbench

Pipeline register stage directly upstream of `alu`. Accepts a decoded operation from the decode stage and selects ALU operands A/B (register, PC or immediate). Resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and presents `A`, `B`, `FUNC` and `sub_sra` to the ALU through a valid/ready handshake. It holds and refreshes operands under backpressure and is cleared by flush.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_fwd_mux.sv | 29 ++
 rtl/alu_issue_stage.sv | 189 ++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue path: widths, ALU FUNC encodings and
// operand-select codes.
package alu_pkg;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  typedef enum logic [2:0] {
    FUNC_ADDSUB = 3'b000,
    FUNC_SLL    = 3'b001,
    FUNC_SLT    = 3'b010,
    FUNC_SLTU   = 3'b011,
    FUNC_XOR    = 3'b100,
    FUNC_SR     = 3'b101,
    FUNC_OR     = 3'b110,
    FUNC_AND    = 3'b111
  } alu_func_e;

  localparam logic ASEL_RS1 = 1'b0;
  localparam logic ASEL_PC  = 1'b1;
  localparam logic BSEL_RS2 = 1'b0;
  localparam logic BSEL_IMM = 1'b1;

endpackage

// File: rtl/alu_fwd_mux.sv
// Priority forward of one register operand: EX/MEM over MEM/WB over the
// fallback value. Register x0 is never forwarded.
module alu_fwd_mux #(
  parameter int XLEN = alu_pkg::XLEN,
  parameter int RA_W = alu_pkg::RA_W
) (
  input  logic [RA_W-1:0] r,
  input  logic [XLEN-1:0] raw,
  input  logic            exm_wr_en,
  input  logic [RA_W-1:0] exm_rd_addr,
  input  logic [XLEN-1:0] exm_rd_data,
  input  logic            wb_wr_en,
  input  logic [RA_W-1:0] wb_rd_addr,
  input  logic [XLEN-1:0] wb_rd_data,
  output logic [XLEN-1:0] data
);

  logic nz;

  always_comb begin
    nz   = (r != '0);
    data = raw;
    if (nz && exm_wr_en && (exm_rd_addr == r))
      data = exm_rd_data;
    else if (nz && wb_wr_en && (wb_rd_addr == r))
      data = wb_rd_data;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue register in front of the ALU: operand select, RAW forwarding with
// refresh while held, flush. Define ALU_ISSUE_SKID_EN for a registered in_ready with one skid entry.
module alu_issue_stage #(
  parameter int XLEN = alu_pkg::XLEN,
  parameter int RA_W = alu_pkg::RA_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [RA_W-1:0] in_rs1_addr,
  input  logic [RA_W-1:0] in_rs2_addr,
  input  logic [RA_W-1:0] in_rd_addr,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_a_sel,
  input  logic            in_b_sel,
  input  logic [2:0]      in_func,
  input  logic            in_sub_sra,
  input  logic            exm_wr_en,
  input  logic [RA_W-1:0] exm_rd_addr,
  input  logic [XLEN-1:0] exm_rd_data,
  input  logic            wb_wr_en,
  input  logic [RA_W-1:0] wb_rd_addr,
  input  logic [XLEN-1:0] wb_rd_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [2:0]      alu_func,
  output logic            alu_sub_sra,
  output logic [RA_W-1:0] out_rd_addr
);

  import alu_pkg::*;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [RA_W-1:0] rd;
    logic            a_sel;
    logic            b_sel;
    logic [2:0]      func;
    logic            sub_sra;
  } entry_t;

  entry_t          cap_p0, ent_p1, ref_p1;
  logic            vld_p1;
  logic [XLEN-1:0] cap_rs1_fwd, cap_rs2_fwd, ref_a_fwd, ref_b_fwd;
  logic            take_in, take_out;

  // p0: capture-side operand select with forwarding
  alu_fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_cap_a (
    .r(in_rs1_addr), .raw(in_rs1_data),
    .exm_wr_en(exm_wr_en), .exm_rd_addr(exm_rd_addr), .exm_rd_data(exm_rd_data),
    .wb_wr_en(wb_wr_en), .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data),
    .data(cap_rs1_fwd));

  alu_fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_cap_b (
    .r(in_rs2_addr), .raw(in_rs2_data),
    .exm_wr_en(exm_wr_en), .exm_rd_addr(exm_rd_addr), .exm_rd_data(exm_rd_data),
    .wb_wr_en(wb_wr_en), .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data),
    .data(cap_rs2_fwd));

  always_comb begin
    cap_p0         = '0;
    cap_p0.a       = (in_a_sel == ASEL_PC)  ? in_pc  : cap_rs1_fwd;
    cap_p0.b       = (in_b_sel == BSEL_IMM) ? in_imm : cap_rs2_fwd;
    cap_p0.rs1     = in_rs1_addr;
    cap_p0.rs2     = in_rs2_addr;
    cap_p0.rd      = in_rd_addr;
    cap_p0.a_sel   = in_a_sel;
    cap_p0.b_sel   = in_b_sel;
    cap_p0.func    = in_func;
    cap_p0.sub_sra = in_sub_sra;
  end

  // p1: refresh of the held main entry; a miss feeds back the stored value
  alu_fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_ref_a (
    .r(ent_p1.rs1), .raw(ent_p1.a),
    .exm_wr_en(exm_wr_en), .exm_rd_addr(exm_rd_addr), .exm_rd_data(exm_rd_data),
    .wb_wr_en(wb_wr_en), .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data),
    .data(ref_a_fwd));

  alu_fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_ref_b (
    .r(ent_p1.rs2), .raw(ent_p1.b),
    .exm_wr_en(exm_wr_en), .exm_rd_addr(exm_rd_addr), .exm_rd_data(exm_rd_data),
    .wb_wr_en(wb_wr_en), .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data),
    .data(ref_b_fwd));

  always_comb begin
    ref_p1   = ent_p1;
    ref_p1.a = (ent_p1.a_sel == ASEL_PC)  ? ent_p1.a : ref_a_fwd;
    ref_p1.b = (ent_p1.b_sel == BSEL_IMM) ? ent_p1.b : ref_b_fwd;
  end

  assign take_in  = in_valid && in_ready;
  assign take_out = vld_p1 && out_ready;

`ifdef ALU_ISSUE_SKID_EN
  entry_t          skid_p1, skid_ref_p1;
  logic            vld_skid_p1;
  logic [XLEN-1:0] skid_a_fwd, skid_b_fwd;

  alu_fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_skid_a (
    .r(skid_p1.rs1), .raw(skid_p1.a),
    .exm_wr_en(exm_wr_en), .exm_rd_addr(exm_rd_addr), .exm_rd_data(exm_rd_data),
    .wb_wr_en(wb_wr_en), .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data),
    .data(skid_a_fwd));

  alu_fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_skid_b (
    .r(skid_p1.rs2), .raw(skid_p1.b),
    .exm_wr_en(exm_wr_en), .exm_rd_addr(exm_rd_addr), .exm_rd_data(exm_rd_data),
    .wb_wr_en(wb_wr_en), .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data),
    .data(skid_b_fwd));

  always_comb begin
    skid_ref_p1   = skid_p1;
    skid_ref_p1.a = (skid_p1.a_sel == ASEL_PC)  ? skid_p1.a : skid_a_fwd;
    skid_ref_p1.b = (skid_p1.b_sel == BSEL_IMM) ? skid_p1.b : skid_b_fwd;
  end

  // Skid occupancy is a flop, so in_ready carries no combinational path.
  assign in_ready = !vld_skid_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      vld_skid_p1 <= 1'b0;
      ent_p1      <= '0;
      skid_p1     <= '0;
    end else if (flush) begin
      vld_p1      <= 1'b0;
      vld_skid_p1 <= 1'b0;
    end else if (take_out) begin
      if (vld_skid_p1) begin
        ent_p1      <= skid_ref_p1;
        vld_skid_p1 <= 1'b0;
      end else if (take_in) begin
        ent_p1 <= cap_p0;
      end else begin
        vld_p1 <= 1'b0;
      end
    end else if (vld_p1) begin
      ent_p1 <= ref_p1;
      if (vld_skid_p1) begin
        skid_p1 <= skid_ref_p1;
      end else if (take_in) begin
        skid_p1     <= cap_p0;
        vld_skid_p1 <= 1'b1;
      end
    end else if (take_in) begin
      ent_p1 <= cap_p0;
      vld_p1 <= 1'b1;
    end
  end
`else
  assign in_ready = !vld_p1 || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      ent_p1 <= '0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (take_in) begin
      vld_p1 <= 1'b1;
      ent_p1 <= cap_p0;
    end else if (take_out) begin
      vld_p1 <= 1'b0;
    end else if (vld_p1) begin
      ent_p1 <= ref_p1;
    end
  end
`endif

  assign out_valid   = vld_p1;
  assign alu_a       = ent_p1.a;
  assign alu_b       = ent_p1.b;
  assign alu_func    = ent_p1.func;
  assign alu_sub_sra = ent_p1.sub_sra;
  assign out_rd_addr = ent_p1.rd;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: scoreboard on the ALU-side handshake plus
// directed scenario tasks; skid scenario only when ALU_ISSUE_SKID_EN is defined.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [31:0] in_rs1_data, in_rs2_data, in_pc, in_imm;
  logic        in_a_sel, in_b_sel, in_sub_sra;
  logic [2:0]  in_func;
  logic        exm_wr_en, wb_wr_en;
  logic [4:0]  exm_rd_addr, wb_rd_addr;
  logic [31:0] exm_rd_data, wb_rd_data;
  logic        out_valid, out_ready, alu_sub_sra;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_func;
  logic [4:0]  out_rd_addr;

  int total = 0;
  int bad   = 0;
  bit sb_en = 1'b0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  func;
    logic        sub_sra;
    logic [4:0]  rd;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_pc(in_pc), .in_imm(in_imm),
    .in_a_sel(in_a_sel), .in_b_sel(in_b_sel), .in_func(in_func), .in_sub_sra(in_sub_sra),
    .exm_wr_en(exm_wr_en), .exm_rd_addr(exm_rd_addr), .exm_rd_data(exm_rd_data),
    .wb_wr_en(wb_wr_en), .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_sub_sra(alu_sub_sra),
    .out_rd_addr(out_rd_addr));

  function automatic logic [31:0] mfwd(input logic [4:0] r, input logic [31:0] raw);
    if (r != 5'd0 && exm_wr_en && exm_rd_addr == r) return exm_rd_data;
    if (r != 5'd0 && wb_wr_en && wb_rd_addr == r) return wb_rd_data;
    return raw;
  endfunction

  // Monitor: pop on transfer-out first, then push the transfer-in of the same cycle.
  always @(negedge clk) begin
    exp_t e, got;
    if (sb_en && rst_n && out_valid && out_ready) begin
      got = '{alu_a, alu_b, alu_func, alu_sub_sra, out_rd_addr};
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected got=%h", got);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          bad++;
          $display("FAIL sb_out got a=%h b=%h f=%0d s=%0d rd=%0d exp a=%h b=%h f=%0d s=%0d rd=%0d",
                   got.a, got.b, got.func, got.sub_sra, got.rd, e.a, e.b, e.func, e.sub_sra, e.rd);
        end
      end
    end
    if (sb_en && rst_n && !flush && in_valid && in_ready) begin
      e.a       = in_a_sel ? in_pc : mfwd(in_rs1_addr, in_rs1_data);
      e.b       = in_b_sel ? in_imm : mfwd(in_rs2_addr, in_rs2_data);
      e.func    = in_func;
      e.sub_sra = in_sub_sra;
      e.rd      = in_rd_addr;
      sb.push_back(e);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    flush = 0; in_valid = 0; out_ready = 1;
    in_rs1_addr = 0; in_rs2_addr = 0; in_rd_addr = 0;
    in_rs1_data = 0; in_rs2_data = 0; in_pc = 0; in_imm = 0;
    in_a_sel = 0; in_b_sel = 0; in_func = 0; in_sub_sra = 0;
    exm_wr_en = 0; exm_rd_addr = 0; exm_rd_data = 0;
    wb_wr_en = 0; wb_rd_addr = 0; wb_rd_data = 0;
  endtask

  task automatic send();
    in_valid = 1;
    step();
    in_valid = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    #12;
    total++;
    if ({out_valid, alu_a, alu_b, alu_func, alu_sub_sra, out_rd_addr, in_ready} !== {1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 5'd0, 1'b1}) begin
      bad++;
      $display("FAIL reset got v=%b a=%h b=%h f=%0d s=%b rd=%0d rdy=%b exp 0/0/0/0/0/0/1",
               out_valid, alu_a, alu_b, alu_func, alu_sub_sra, out_rd_addr, in_ready);
    end
    @(negedge clk);
    rst_n = 1;
    step();
  endtask

  task automatic test_pc_imm();
    sb_en = 1;
    in_a_sel = 1; in_pc = 32'h0000_1000;
    in_b_sel = 1; in_imm = 32'hFFFF_F000;
    in_func = 3'b000; in_sub_sra = 1; in_rd_addr = 5'd3;
    send();
    total++;
    if ({out_valid, alu_a, alu_b, alu_sub_sra} !== {1'b1, 32'h0000_1000, 32'hFFFF_F000, 1'b1}) begin
      bad++;
      $display("FAIL pc_imm got v=%b a=%h b=%h s=%b exp 1 00001000 fffff000 1",
               out_valid, alu_a, alu_b, alu_sub_sra);
    end
    step();
  endtask

  task automatic test_forward();
    clear_inputs();
    in_rs1_addr = 5; in_rs1_data = 32'd1; in_b_sel = 1; in_imm = 32'd9; in_func = 3'b110;
    exm_wr_en = 1; exm_rd_addr = 5; exm_rd_data = 32'hC000_0000;
    wb_wr_en = 1; wb_rd_addr = 5; wb_rd_data = 32'd2;
    send();
    exm_wr_en = 0; wb_wr_en = 0;
    total++;
    if (alu_a !== 32'hC000_0000) begin
      bad++;
      $display("FAIL fwd_exm got=%h exp=c0000000", alu_a);
    end
    exm_wr_en = 0; wb_wr_en = 1;
    send();
    wb_wr_en = 0;
    total++;
    if (alu_a !== 32'd2) begin
      bad++;
      $display("FAIL fwd_wb got=%h exp=00000002", alu_a);
    end
    // rs2 path via MEM/WB, rs1 untouched
    in_b_sel = 0; in_rs2_addr = 12; in_rs2_data = 32'h55;
    wb_wr_en = 1; wb_rd_addr = 12; wb_rd_data = 32'hABCD_0001;
    send();
    wb_wr_en = 0;
    total++;
    if ({alu_a, alu_b} !== {32'd1, 32'hABCD_0001}) begin
      bad++;
      $display("FAIL fwd_rs2 got a=%h b=%h exp a=00000001 b=abcd0001", alu_a, alu_b);
    end
    step();
  endtask

  task automatic test_x0();
    clear_inputs();
    in_rs1_addr = 0; in_rs1_data = 0; in_b_sel = 1; in_imm = 32'd4;
    exm_wr_en = 1; exm_rd_addr = 0; exm_rd_data = 32'hDEAD_BEEF;
    send();
    exm_wr_en = 0;
    total++;
    if (alu_a !== 32'd0) begin
      bad++;
      $display("FAIL x0_nofwd got=%h exp=00000000", alu_a);
    end
    step();
  endtask

  task automatic test_refresh();
    clear_inputs();
    sb_en = 0;
    out_ready = 0;
    in_rs2_addr = 7; in_rs2_data = 32'h11;
    in_a_sel = 1; in_pc = 32'h400; in_rs1_addr = 7;
    send();
    step(); step();
    total++;
    if ({out_valid, alu_b} !== {1'b1, 32'h11}) begin
      bad++;
      $display("FAIL hold_stable got v=%b b=%h exp v=1 b=00000011", out_valid, alu_b);
    end
`ifndef ALU_ISSUE_SKID_EN
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL ready_held got=%b exp=0", in_ready);
    end
`endif
    wb_wr_en = 1; wb_rd_addr = 7; wb_rd_data = 32'hFFFF_F000;
    step();
    wb_wr_en = 0;
    total++;
    if ({out_valid, alu_b, alu_a} !== {1'b1, 32'hFFFF_F000, 32'h400}) begin
      bad++;
      $display("FAIL refresh got v=%b b=%h a=%h exp v=1 b=fffff000 a=00000400", out_valid, alu_b, alu_a);
    end
    step();
    total++;
    if (alu_b !== 32'hFFFF_F000) begin
      bad++;
      $display("FAIL refresh_keep got=%h exp=fffff000", alu_b);
    end
    out_ready = 1;
    step();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL drain got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_flush();
    clear_inputs();
    sb_en = 0;
    out_ready = 0;
    in_b_sel = 1; in_imm = 32'h77;
    send();
    flush = 1; in_valid = 1; in_imm = 32'h88;
    step();
    flush = 0; in_valid = 0;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush got=%b exp=0", out_valid);
    end
    out_ready = 1;
    step();
  endtask

  task automatic test_async_reset();
    clear_inputs();
    sb_en = 0;
    out_ready = 0;
    in_a_sel = 1; in_pc = 32'h1234;
    send();
    #2 rst_n = 0;
    #1;
    total++;
    if ({out_valid, alu_a} !== {1'b0, 32'd0}) begin
      bad++;
      $display("FAIL async_reset got v=%b a=%h exp v=0 a=00000000", out_valid, alu_a);
    end
    @(negedge clk);
    rst_n = 1;
    out_ready = 1;
    step();
  endtask

  task automatic rand_op(input bit with_fwd);
    in_rs1_addr = 5'($urandom_range(0, 3)); in_rs2_addr = 5'($urandom_range(0, 3));
    in_rd_addr = 5'($urandom); in_rs1_data = $urandom; in_rs2_data = $urandom;
    in_pc = $urandom; in_imm = $urandom;
    in_a_sel = 1'($urandom); in_b_sel = 1'($urandom);
    in_func = 3'($urandom); in_sub_sra = 1'($urandom);
    exm_wr_en = with_fwd & 1'($urandom); exm_rd_addr = 5'($urandom_range(0, 3)); exm_rd_data = $urandom;
    wb_wr_en = with_fwd & 1'($urandom); wb_rd_addr = 5'($urandom_range(0, 3)); wb_rd_data = $urandom;
  endtask

  task automatic test_back_to_back();
    for (int phase = 0; phase < 2; phase++) begin
      int sent = 0;
      int guard = 0;
      bit acc;
      clear_inputs();
      sb_en = 1;
      rand_op(phase == 0);
      while (sent < 20 && guard < 400) begin
        out_ready = (phase == 0) ? 1'b1 : 1'($urandom);
        in_valid = 1;
        @(negedge clk);
        acc = in_ready;
        step();
        if (acc) begin
          sent++;
          rand_op(phase == 0);
        end
        guard++;
      end
      in_valid = 0; exm_wr_en = 0; wb_wr_en = 0;
      total++;
      if (guard >= 400) begin
        bad++;
        $display("FAIL b2b_timeout phase=%0d sent=%0d exp=20", phase, sent);
      end
      out_ready = 1;
      repeat (4) step();
      total++;
      if (sb.size() != 0) begin
        bad++;
        $display("FAIL b2b_drain left=%0d exp=0", sb.size());
      end
    end
  endtask

`ifdef ALU_ISSUE_SKID_EN
  task automatic test_skid();
    clear_inputs();
    sb_en = 1;
    out_ready = 0;
    in_a_sel = 1; in_b_sel = 1; in_pc = 32'hA1; in_imm = 32'hB1;
    send();
    in_pc = 32'hA2; in_imm = 32'hB2;
    send();
    total++;
    if ({in_ready, out_valid, alu_a} !== {1'b0, 1'b1, 32'hA1}) begin
      bad++;
      $display("FAIL skid_full got rdy=%b v=%b a=%h exp rdy=0 v=1 a=000000a1", in_ready, out_valid, alu_a);
    end
    out_ready = 1;
    step();
    total++;
    if ({in_ready, out_valid, alu_a} !== {1'b1, 1'b1, 32'hA2}) begin
      bad++;
      $display("FAIL skid_move got rdy=%b v=%b a=%h exp rdy=1 v=1 a=000000a2", in_ready, out_valid, alu_a);
    end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_pc_imm();
    test_forward();
    test_x0();
    test_refresh();
    test_flush();
    test_async_reset();
    test_back_to_back();
`ifdef ALU_ISSUE_SKID_EN
    test_skid();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
